forward_ctrl: RTL and testbench
===============================

FORWARD_CTRL -- requirements
Module: forward_ctrl

Interface
REQ-001 SHALL have parameter REG_ADDR_W, default 5, register-address width.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port arst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port enable  input  1  pipeline advance; 0 freezes all internal state.
REQ-005 SHALL have port flush  input  1  taken-branch squash of ID/EX and EX/MEM copies.
REQ-006 SHALL have port id_rs1  input  REG_ADDR_W  ID-stage source register 1.
REQ-007 SHALL have port id_rs2  input  REG_ADDR_W  ID-stage source register 2.
REQ-008 SHALL have port id_rd  input  REG_ADDR_W  ID-stage destination register.
REQ-009 SHALL have port id_reg_write  input  1  ID-stage instruction writes rd.
REQ-010 SHALL have port id_mem_read  input  1  ID-stage instruction is a load.
REQ-011 SHALL have port fwd_sel_a  output  2  EX operand-A select for the 3-input forwarding mux.
REQ-012 SHALL have port fwd_sel_b  output  2  EX operand-B select, same encoding.
REQ-013 SHALL have port stall  output  1  load-use hazard; hold PC and IF/ID.

Function
REQ-014 Select encoding SHALL be: 00 register-file value; 01 EX/MEM result; 1x (driven as 10) MEM/WB result.
REQ-015 Block SHALL hold shadow stages ID/EX {rs1, rs2, rd, reg_write, mem_read}, EX/MEM {rd, reg_write, mem_read}, MEM/WB {rd, reg_write}.
REQ-016 On clk rise with enable=1, flush=0, stall=0: ID inputs -> ID/EX, ID/EX -> EX/MEM, EX/MEM -> MEM/WB.
REQ-017 With stall=1 (enable=1, flush=0), ID/EX SHALL load a bubble (reg_write=0, mem_read=0, addresses 0); EX/MEM and MEM/WB still advance.
REQ-018 With flush=1 (enable=1), ID/EX and EX/MEM SHALL load bubbles; MEM/WB advances from EX/MEM; flush overrides stall.
REQ-019 With enable=0, every shadow register SHALL hold, regardless of flush/stall.
REQ-020 fwd_sel_a SHALL be 01 when EX/MEM.reg_write=1, EX/MEM.rd!=0, EX/MEM.rd==ID/EX.rs1.
REQ-021 Otherwise fwd_sel_a SHALL be 10 when MEM/WB.reg_write=1, MEM/WB.rd!=0, MEM/WB.rd==ID/EX.rs1; else 00.
REQ-022 fwd_sel_b SHALL follow REQ-020/021 against ID/EX.rs2.
REQ-023 Both stages matching SHALL give EX/MEM priority (youngest producer wins).
REQ-024 Register 0 SHALL never be forwarded nor cause stall.
REQ-025 stall SHALL be 1 when ID/EX.mem_read=1, ID/EX.rd!=0, and ID/EX.rd equals id_rs1 or id_rs2; else 0.
REQ-026 All outputs SHALL be combinational functions of shadow registers and current ID inputs; zero-cycle latency to EX.
REQ-027 A load followed by a dependent instruction SHALL stall exactly one cycle, then forward via 10 from MEM/WB.

Reset
REQ-028 arst_n=0 SHALL immediately clear all shadow registers to 0, independent of clk.
REQ-029 During and after reset, until the first advance, fwd_sel_a=00, fwd_sel_b=00, stall=0.
REQ-030 Reset asserted mid-stall SHALL drop stall to 0 within the same cycle.

Structure
REQ-031 Select encodings (FWD_RF=00, FWD_EXMEM=01, FWD_MEMWB=10) and REG_ADDR_W default SHALL live in the shared package.
REQ-032 A sub-module fwd_compare (one operand: address in, two stage matches, select out) SHALL be instantiated twice for sel_a/sel_b.

Verification
REQ-033 Reset released, id_* all 0, 3 advances -> sel_a=sel_b=00, stall=0 every cycle.
REQ-034 add x5 (reg_write) then sub using rs1=x5 -> next cycle fwd_sel_a=01; one cycle later with unrelated instr in between -> 10.
REQ-035 lw x7 then add rs2=x7 -> stall=1 one cycle, bubble in ID/EX, next cycle fwd_sel_b=10, stall=0.
REQ-036 Writes to x3 in EX/MEM and MEM/WB, consumer rs1=rs2=x3 -> sel_a=sel_b=01; writes to x0 -> 00.
REQ-037 flush=1 with load-use pending -> stall=0 next cycle, ID/EX and EX/MEM bubbles, no forwarding from squashed rd.
REQ-038 enable=0 for 4 cycles mid-sequence -> outputs constant; arst_n pulse mid-stall -> all outputs 00/0 asynchronously.

Source files
------------

// File: rtl/forward_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : forward_ctrl_pkg
// Purpose  : Shared constants for the EX-stage forwarding/hazard controller.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
package forward_ctrl_pkg;

  // Default register-address width (32 architectural registers).
  localparam int REG_ADDR_W_DEFAULT = 5;

  // Operand select encoding for the EX-stage 3-input forwarding mux.
  localparam logic [1:0] FWD_RF    = 2'b00;  // register-file value
  localparam logic [1:0] FWD_EXMEM = 2'b01;  // EX/MEM result (youngest)
  localparam logic [1:0] FWD_MEMWB = 2'b10;  // MEM/WB result

endpackage : forward_ctrl_pkg
`default_nettype wire

// File: rtl/forward_ctrl_fwd_compare.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : fwd_compare
// Purpose  : Forwarding select for one EX operand. Matches the operand's
//            source address against the EX/MEM and MEM/WB producers; the
//            younger EX/MEM producer wins, and x0 is never forwarded.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module fwd_compare
  import forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic [REG_ADDR_W-1:0] exmem_rd,
  input  logic                  exmem_reg_write,
  input  logic [REG_ADDR_W-1:0] memwb_rd,
  input  logic                  memwb_reg_write,
  output logic [1:0]            sel
);

  logic w_exmem_hit;
  logic w_memwb_hit;

  assign w_exmem_hit = exmem_reg_write && (exmem_rd != '0) && (exmem_rd == src);
  assign w_memwb_hit = memwb_reg_write && (memwb_rd != '0) && (memwb_rd == src);

  // Priority select: EX/MEM first, then MEM/WB, else register file.
  always_comb begin
    sel = FWD_RF;
    if (w_exmem_hit) begin
      sel = FWD_EXMEM;
    end else if (w_memwb_hit) begin
      sel = FWD_MEMWB;
    end
  end

endmodule : fwd_compare
`default_nettype wire

// File: rtl/forward_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : forward_ctrl
// Purpose  : Shadow-pipeline forwarding and load-use hazard controller.
//            Tracks ID/EX, EX/MEM and MEM/WB copies of register usage and
//            produces EX operand selects plus a one-cycle load-use stall.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
module forward_ctrl
  import forward_ctrl_pkg::*;
#(
  parameter int REG_ADDR_W = REG_ADDR_W_DEFAULT
) (
  input  logic                  clk,
  input  logic                  arst_n,
  input  logic                  enable,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_reg_write,
  input  logic                  id_mem_read,
  output logic [1:0]            fwd_sel_a,
  output logic [1:0]            fwd_sel_b,
  output logic                  stall
);

  // ID/EX shadow
  logic [REG_ADDR_W-1:0] r_idex_rs1;
  logic [REG_ADDR_W-1:0] r_idex_rs2;
  logic [REG_ADDR_W-1:0] r_idex_rd;
  logic                  r_idex_reg_write;
  logic                  r_idex_mem_read;
  // EX/MEM shadow
  logic [REG_ADDR_W-1:0] r_exmem_rd;
  logic                  r_exmem_reg_write;
  logic                  r_exmem_mem_read;
  // MEM/WB shadow
  logic [REG_ADDR_W-1:0] r_memwb_rd;
  logic                  r_memwb_reg_write;

  // Load in EX whose destination is read by the instruction now in ID.
  logic w_load_use;
  assign w_load_use = r_idex_mem_read && (r_idex_rd != '0) &&
                      ((r_idex_rd == id_rs1) || (r_idex_rd == id_rs2));
  assign stall = w_load_use;

  // Shadow pipeline advance; flush squashes ID/EX and EX/MEM, stall
  // injects a bubble into ID/EX only, enable=0 freezes everything.
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_idex_rs1        <= '0;
      r_idex_rs2        <= '0;
      r_idex_rd         <= '0;
      r_idex_reg_write  <= 1'b0;
      r_idex_mem_read   <= 1'b0;
      r_exmem_rd        <= '0;
      r_exmem_reg_write <= 1'b0;
      r_exmem_mem_read  <= 1'b0;
      r_memwb_rd        <= '0;
      r_memwb_reg_write <= 1'b0;
    end else if (enable) begin
      r_memwb_rd        <= r_exmem_rd;
      r_memwb_reg_write <= r_exmem_reg_write;
      if (flush) begin
        r_exmem_rd        <= '0;
        r_exmem_reg_write <= 1'b0;
        r_exmem_mem_read  <= 1'b0;
      end else begin
        r_exmem_rd        <= r_idex_rd;
        r_exmem_reg_write <= r_idex_reg_write;
        r_exmem_mem_read  <= r_idex_mem_read;
      end
      if (flush || w_load_use) begin
        r_idex_rs1       <= '0;
        r_idex_rs2       <= '0;
        r_idex_rd        <= '0;
        r_idex_reg_write <= 1'b0;
        r_idex_mem_read  <= 1'b0;
      end else begin
        r_idex_rs1       <= id_rs1;
        r_idex_rs2       <= id_rs2;
        r_idex_rd        <= id_rd;
        r_idex_reg_write <= id_reg_write;
        r_idex_mem_read  <= id_mem_read;
      end
    end
  end

  fwd_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_a (
    .src             (r_idex_rs1),
    .exmem_rd        (r_exmem_rd),
    .exmem_reg_write (r_exmem_reg_write),
    .memwb_rd        (r_memwb_rd),
    .memwb_reg_write (r_memwb_reg_write),
    .sel             (fwd_sel_a)
  );

  fwd_compare #(.REG_ADDR_W(REG_ADDR_W)) u_cmp_b (
    .src             (r_idex_rs2),
    .exmem_rd        (r_exmem_rd),
    .exmem_reg_write (r_exmem_reg_write),
    .memwb_rd        (r_memwb_rd),
    .memwb_reg_write (r_memwb_reg_write),
    .sel             (fwd_sel_b)
  );

endmodule : forward_ctrl
`default_nettype wire

// File: tb/tb_forward_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_forward_ctrl
// Purpose  : Self-checking bench for forward_ctrl with an in-bench
//            instruction-level pipeline model.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_forward_ctrl;

  logic       clk = 1'b0;
  logic       arst_n = 1'b1;
  logic       enable = 1'b1;
  logic       flush = 1'b0;
  logic [4:0] id_rs1 = '0;
  logic [4:0] id_rs2 = '0;
  logic [4:0] id_rd = '0;
  logic       id_reg_write = 1'b0;
  logic       id_mem_read = 1'b0;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       stall;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  forward_ctrl #(.REG_ADDR_W(5)) dut (
    .clk          (clk),
    .arst_n       (arst_n),
    .enable       (enable),
    .flush        (flush),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .fwd_sel_a    (fwd_sel_a),
    .fwd_sel_b    (fwd_sel_b),
    .stall        (stall)
  );

  always #5 clk = ~clk;

  // Instruction record as seen by the model: one entry per pipeline slot.
  typedef struct packed {
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       rw;
    logic       mr;
  } instr_t;

  localparam instr_t BUBBLE = '0;

  instr_t m_ex, m_mem, m_wb;   // instruction in EX, MEM, WB
  initial begin
    m_ex = BUBBLE; m_mem = BUBBLE; m_wb = BUBBLE;
  end

  // Does instruction p produce register r usefully (x0 excluded)?
  function automatic bit writes(instr_t p, logic [4:0] r);
    return p.rw && (p.rd != 5'd0) && (p.rd == r);
  endfunction

  // Youngest in-flight producer of r decides the source.
  function automatic logic [1:0] exp_sel(logic [4:0] r);
    if (writes(m_mem, r)) return 2'b01;
    if (writes(m_wb, r))  return 2'b10;
    return 2'b00;
  endfunction

  function automatic logic exp_stall();
    return m_ex.mr && (m_ex.rd != 5'd0) &&
           ((m_ex.rd == id_rs1) || (m_ex.rd == id_rs2));
  endfunction

  // Model pipeline motion, one instruction slot per clock.
  always @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      m_ex <= BUBBLE; m_mem <= BUBBLE; m_wb <= BUBBLE;
    end else if (enable) begin
      m_wb  <= m_mem;
      m_mem <= flush ? BUBBLE : m_ex;
      m_ex  <= (flush || exp_stall()) ? BUBBLE
               : instr_t'{id_rs1, id_rs2, id_rd, id_reg_write, id_mem_read};
    end
  end

  task automatic chk(input string name, input logic [1:0] act, input logic [1:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  // Compare DUT to the model every cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_sel_a", fwd_sel_a, exp_sel(m_ex.rs1));
      chk("cyc_sel_b", fwd_sel_b, exp_sel(m_ex.rs2));
      chk("cyc_stall", {1'b0, stall}, {1'b0, exp_stall()});
    end
  end

  task automatic ins(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                     input logic rw, input logic mr);
    id_rs1 = rs1; id_rs2 = rs2; id_rd = rd; id_reg_write = rw; id_mem_read = mr;
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic chk_out(input string name, input logic [1:0] a, input logic [1:0] b,
                         input logic s);
    chk({name, "_a"}, fwd_sel_a, a);
    chk({name, "_b"}, fwd_sel_b, b);
    chk({name, "_stall"}, {1'b0, stall}, {1'b0, s});
  endtask

  initial begin
    #1 arst_n = 1'b0;
    #2;
    chk_out("reset", 2'b00, 2'b00, 1'b0);
    chk_on = 1'b1;
    @(negedge clk); #1 arst_n = 1'b1;

    // Idle pipeline stays quiet.
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("idle", 2'b00, 2'b00, 1'b0);
    end

    // add x5 ; sub rs1=x5 -> EX/MEM forward.
    ins(5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
    ins(5'd5, 5'd6, 5'd8, 1'b1, 1'b0); tick();
    chk_out("exmem_fwd", 2'b01, 2'b00, 1'b0);
    chk("model_exmem", exp_sel(m_ex.rs1), 2'b01);

    // add x5 ; nop ; sub rs1=x5 -> MEM/WB forward.
    ins(5'd1, 5'd2, 5'd5, 1'b1, 1'b0); tick();
    ins(5'd0, 5'd0, 5'd0, 1'b0, 1'b0); tick();
    ins(5'd5, 5'd0, 5'd9, 1'b1, 1'b0); tick();
    chk_out("memwb_fwd", 2'b10, 2'b00, 1'b0);
    chk("model_memwb", exp_sel(m_ex.rs1), 2'b10);

    // lw x7 ; add rs2=x7 -> one stall, bubble, then MEM/WB forward.
    ins(5'd1, 5'd0, 5'd7, 1'b1, 1'b1); tick();
    ins(5'd2, 5'd7, 5'd9, 1'b1, 1'b0); #1;
    chk("lu_stall", {1'b0, stall}, 2'b01);
    chk("model_lu_stall", {1'b0, exp_stall()}, 2'b01);
    tick();
    chk_out("lu_bubble", 2'b00, 2'b00, 1'b0);
    tick();
    chk_out("lu_fwd", 2'b00, 2'b10, 1'b0);

    // Double producer of x3: youngest wins; x0 producers are ignored.
    ins(5'd0, 5'd0, 5'd3, 1'b1, 1'b0); tick();
    ins(5'd0, 5'd0, 5'd3, 1'b1, 1'b0); tick();
    ins(5'd3, 5'd3, 5'd10, 1'b1, 1'b0); tick();
    chk_out("prio", 2'b01, 2'b01, 1'b0);
    ins(5'd0, 5'd0, 5'd0, 1'b1, 1'b0); tick();
    ins(5'd0, 5'd0, 5'd0, 1'b1, 1'b0); tick();
    ins(5'd0, 5'd0, 5'd10, 1'b1, 1'b0); tick();
    chk_out("x0", 2'b00, 2'b00, 1'b0);

    // Flush while a load-use hazard is pending.
    ins(5'd0, 5'd0, 5'd7, 1'b1, 1'b1); tick();
    ins(5'd7, 5'd0, 5'd12, 1'b1, 1'b0); #1;
    chk("fl_pre_stall", {1'b0, stall}, 2'b01);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk_out("fl_after", 2'b00, 2'b00, 1'b0);
    tick();
    chk_out("fl_nofwd", 2'b00, 2'b00, 1'b0);

    // Freeze during a stall with an EX/MEM forward active.
    ins(5'd12, 5'd0, 5'd7, 1'b1, 1'b1); tick();
    ins(5'd7, 5'd12, 5'd13, 1'b1, 1'b0); #1;
    chk_out("frz_pre", 2'b01, 2'b00, 1'b1);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      flush = 1'($urandom_range(0, 1));
      tick();
      chk_out("frz", 2'b01, 2'b00, 1'b1);
    end
    flush = 1'b0;

    // Asynchronous reset pulse mid-stall, no clock edge in between.
    #1 arst_n = 1'b0;
    #1;
    chk_out("async_rst", 2'b00, 2'b00, 1'b0);
    arst_n = 1'b1;
    enable = 1'b1;
    tick();

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 500; i++) begin
      ins(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
          1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0));
      enable = ($urandom_range(0, 9) != 0);
      flush  = ($urandom_range(0, 9) == 0);
      tick();
    end

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule : tb_forward_ctrl
`default_nettype wire
